// File: rtl/csa_psum_accumulator.sv
// Partial-sum accumulator behind carry_save_adder: sums a group of beats, then scales and saturates the total.
// Optional macro CSA_ACC_ROUND_EN selects round-half-up before the shift; otherwise the shift truncates.
module csa_psum_accumulator #(
    parameter int W         = 4,
    parameter int E         = 3,
    parameter int ACC_W     = 16,
    parameter int OUT_W     = 8,
    parameter int SHIFT     = 2,
    parameter int MAX_BEATS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W+E:0]     in_sum,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_err
);

    localparam int IW    = W + E + 1;
    localparam int VW    = ACC_W + 1;
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

`ifdef CSA_ACC_ROUND_EN
    localparam logic [VW-1:0] RND = (SHIFT > 0) ? (VW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`else
    localparam logic [VW-1:0] RND = '0;
`endif

    generate
        if (ACC_W < IW + $clog2(MAX_BEATS)) begin : g_acc_w_check
            $error("ACC_W too narrow for IW and MAX_BEATS");
        end
        if (SHIFT < 0 || SHIFT > ACC_W - 1) begin : g_shift_check
            $error("SHIFT out of range 0..ACC_W-1");
        end
    endgenerate

    typedef enum logic {IDLE, ACC} state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q;
    logic [OUT_W-1:0]   data_q, data_d;
    logic               sat_q, sat_d;
    logic               err_q, err_d;
    logic               accept;
    logic               close;
    logic [VW-1:0]      rounded;
    logic [VW-1:0]      scaled;

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sat   = sat_q;
    assign out_err   = err_q;

    always_comb begin
        accept  = in_valid & in_ready;
        acc_d   = (state_q == IDLE) ? ACC_W'(in_sum) : acc_q + ACC_W'(in_sum);
        cnt_d   = cnt_q + 1'b1;
        close   = accept & (in_last | (cnt_d == CNT_W'(MAX_BEATS)));
        err_d   = ~in_last;
        rounded = {1'b0, acc_d} + RND;
        scaled  = rounded >> SHIFT;
    end

    // Any bit above the output field means the scaled value does not fit.
    generate
        if (OUT_W < VW) begin : g_sat
            assign sat_d  = |scaled[VW-1:OUT_W];
            assign data_d = sat_d ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
        end else begin : g_nosat
            assign sat_d  = 1'b0;
            assign data_d = OUT_W'(scaled);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (close) begin
            // A close can coincide with a drain; the new result simply replaces the old one.
            state_q <= IDLE;
            acc_q   <= acc_d;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            data_q  <= data_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
        end else begin
            if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end
            if (accept) begin
                state_q <= ACC;
                acc_q   <= acc_d;
                cnt_q   <= cnt_d;
            end
        end
    end

endmodule
